// File: rtl/display_pkg.sv
// Shared constants and command-FSM state type for the display frame-buffer path.
package display_pkg;

  localparam int DEFAULT_ADDR_W = 8;

  localparam logic [7:0] CMD_WRITE = 8'hF0;
  localparam logic [7:0] CMD_SWAP  = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    IGNORE
  } fsm_state_t;

endpackage

// File: rtl/fb_port_arbiter.sv
// Single-entry write buffer and RAM port mux; scan-out reads always take the port.
module fb_port_arbiter
  import display_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  input  logic              disp_bank,
  input  logic              wr_req,
  input  logic [ADDR_W:0]   wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_accept,
  output logic              scan_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_addr,
  output logic [7:0]        mem_wdata
);

  logic              pend;
  logic [ADDR_W:0]   pend_addr;
  logic [7:0]        pend_data;
  logic              issue;

  // A queued write drains only when no scan read claims the port; reset blocks it outright.
  assign issue     = pend && !scan_req && !rst;
  assign wr_accept = wr_req && !rst && (!pend || issue);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend        <= 1'b0;
      pend_addr   <= '0;
      pend_data   <= '0;
      scan_rvalid <= 1'b0;
    end else begin
      scan_rvalid <= scan_req;
      if (wr_accept) begin
        pend      <= 1'b1;
        pend_addr <= wr_addr;
        pend_data <= wr_data;
      end else if (issue) begin
        pend <= 1'b0;
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      if (scan_req) begin
        mem_en   = 1'b1;
        mem_addr = {disp_bank, scan_addr};
      end else if (pend) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = pend_addr;
        mem_wdata = pend_data;
      end
    end
  end

endmodule

// File: rtl/spi_fb_write_ctrl.sv
// Decodes the SPI byte stream into frame-buffer writes and manages the display bank swap.
module spi_fb_write_ctrl
  import display_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_active,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  input  logic              frame_sync,
  output logic              scan_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              disp_bank,
  output logic              swap_pending,
  output logic              overflow
);

  fsm_state_t        state;
  fsm_state_t        state_next;
  logic              fa_q;
  logic              frame_rise;
  logic [ADDR_W-1:0] addr_cnt;
  logic              wr_req;
  logic              wr_accept;
  logic              load_addr;
  logic              swap_set;

  assign frame_rise = frame_active && !fa_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A byte arriving on the falling-edge cycle is still decoded; the frame closes afterwards.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (frame_rise) state_next = CMD;
      CMD:     if (rx_valid) state_next = (rx_data == CMD_WRITE) ? ADDR : IGNORE;
      ADDR:    if (rx_valid) state_next = DATA;
      DATA:    state_next = DATA;
      IGNORE:  state_next = IGNORE;
      default: state_next = IDLE;
    endcase
    if (!frame_active) state_next = IDLE;
  end

  always_comb begin
    wr_req    = 1'b0;
    load_addr = 1'b0;
    swap_set  = 1'b0;
    unique case (state)
      CMD:     swap_set  = rx_valid && (rx_data == CMD_SWAP);
      ADDR:    load_addr = rx_valid;
      DATA:    wr_req    = rx_valid;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fa_q     <= 1'b0;
      addr_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      fa_q <= frame_active;
      if (load_addr)      addr_cnt <= ADDR_W'(rx_data);
      else if (wr_accept) addr_cnt <= addr_cnt + ADDR_W'(1);
      if (frame_rise)                overflow <= 1'b0;
      else if (wr_req && !wr_accept) overflow <= 1'b1;
    end
  end

  // A swap requested in the same cycle as frame_sync is held for the following boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_bank    <= 1'b0;
      swap_pending <= 1'b0;
    end else if (frame_sync && swap_pending) begin
      disp_bank    <= ~disp_bank;
      swap_pending <= 1'b0;
    end else if (swap_set) begin
      swap_pending <= 1'b1;
    end
  end

  fb_port_arbiter #(.ADDR_W(ADDR_W)) u_arbiter (
    .clk         (clk),
    .rst         (rst),
    .scan_req    (scan_req),
    .scan_addr   (scan_addr),
    .disp_bank   (disp_bank),
    .wr_req      (wr_req),
    .wr_addr     ({~disp_bank, addr_cnt}),
    .wr_data     (rx_data),
    .wr_accept   (wr_accept),
    .scan_rvalid (scan_rvalid),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata)
  );

endmodule

// File: tb/tb_spi_fb_write_ctrl.sv
// Bench for spi_fb_write_ctrl: directed scenarios then random frames against a byte-indexed model.
module tb_spi_fb_write_ctrl;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_active;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          scan_req;
  logic [AW-1:0] scan_addr;
  logic          frame_sync;
  logic          scan_rvalid;
  logic          mem_en;
  logic          mem_we;
  logic [AW:0]   mem_addr;
  logic [7:0]    mem_wdata;
  logic          disp_bank;
  logic          swap_pending;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  bit         m_init = 0;
  bit         m_open, m_pend, m_bank, m_swp, m_ovf, m_prev_scan, m_fa_prev;
  int         m_idx;
  logic [7:0] m_cmd, m_addr, m_pdata;
  logic [8:0] m_paddr;
  logic [7:0] ram [0:511];

  spi_fb_write_ctrl #(.ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_active (frame_active),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .scan_req     (scan_req),
    .scan_addr    (scan_addr),
    .frame_sync   (frame_sync),
    .scan_rvalid  (scan_rvalid),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .disp_bank    (disp_bank),
    .swap_pending (swap_pending),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model view: a frame is a numbered byte sequence; byte 0 is the command, byte 1 the
  // start address for a write, and every later byte a data write to the hidden bank.
  task automatic modelUpdate(input bit r, input bit f, input bit v, input logic [7:0] d,
                             input bit s, input bit fs);
    bit issue, rising, acc, sw;
    logic [8:0] na;
    logic [7:0] nd;
    if (r) begin
      m_init = 1; m_open = 0; m_idx = 0; m_cmd = 0; m_addr = 0; m_pend = 0;
      m_paddr = 0; m_pdata = 0; m_bank = 0; m_swp = 0; m_ovf = 0;
      m_prev_scan = 0; m_fa_prev = 0;
      return;
    end
    issue  = m_pend && !s;
    rising = f && !m_fa_prev;
    acc = 0; sw = 0; na = 0; nd = 0;
    if (m_open && v) begin
      if (m_idx == 0) begin
        m_cmd = d;
        sw = (d == 8'hA5);
      end else if (m_cmd == 8'hF0 && m_idx == 1) begin
        m_addr = d;
      end else if (m_cmd == 8'hF0) begin
        if (!m_pend || issue) begin
          acc = 1; na = {~m_bank, m_addr}; nd = d;
          m_addr = m_addr + 8'd1;
        end else begin
          m_ovf = 1;
        end
      end
      m_idx++;
    end
    if (acc) begin
      m_pend = 1; m_paddr = na; m_pdata = nd;
    end else if (issue) begin
      m_pend = 0;
    end
    if (fs && m_swp) begin
      m_bank = ~m_bank; m_swp = 0;
    end else if (sw) begin
      m_swp = 1;
    end
    if (rising) m_ovf = 0;
    if (!f) m_open = 0;
    else if (rising) begin m_open = 1; m_idx = 0; end
    m_prev_scan = s;
    m_fa_prev   = f;
  endtask

  task automatic applyStimulus(input bit r, input bit f, input bit v, input logic [7:0] d,
                               input bit s, input bit fs);
    rst = r; frame_active = f; rx_valid = v; rx_data = d;
    scan_req = s; scan_addr = AW'($urandom); frame_sync = fs;
    @(negedge clk);
    if (r) begin
      checkOutput("rst_mem_en", mem_en, 0);
      checkOutput("rst_mem_we", mem_we, 0);
      checkOutput("rst_mem_addr", mem_addr, 0);
      checkOutput("rst_mem_wdata", mem_wdata, 0);
    end else if (s) begin
      checkOutput("rd_mem_en", mem_en, 1);
      checkOutput("rd_mem_we", mem_we, 0);
      checkOutput("rd_mem_addr", mem_addr, {m_bank, scan_addr});
    end else if (m_pend) begin
      checkOutput("wr_mem_en", mem_en, 1);
      checkOutput("wr_mem_we", mem_we, 1);
      checkOutput("wr_mem_addr", mem_addr, m_paddr);
      checkOutput("wr_mem_wdata", mem_wdata, m_pdata);
    end else begin
      checkOutput("idle_mem_en", mem_en, 0);
      checkOutput("idle_mem_we", mem_we, 0);
    end
    if (m_init) begin
      checkOutput("scan_rvalid", scan_rvalid, m_prev_scan);
      checkOutput("disp_bank", disp_bank, m_bank);
      checkOutput("swap_pending", swap_pending, m_swp);
      checkOutput("overflow", overflow, m_ovf);
    end
    if (!r && mem_en === 1'b1 && mem_we === 1'b1 && !$isunknown(mem_addr))
      ram[mem_addr] = mem_wdata;
    modelUpdate(r, f, v, d, s, fs);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit f, input bit s);
    repeat (n) applyStimulus(0, f, 0, 8'h00, s, 0);
  endtask

  task automatic sendByte(input logic [7:0] b, input bit s);
    applyStimulus(0, 1, 1, b, s, 0);
  endtask

  initial begin
    logic [7:0] b;
    int n;
    for (int i = 0; i < 512; i++) ram[i] = 8'h5A;
    rst = 1; frame_active = 0; rx_valid = 0; rx_data = 0;
    scan_req = 0; scan_addr = 0; frame_sync = 0;
    @(posedge clk);
    #1;
    repeat (3) applyStimulus(1, 0, 0, 8'h00, 0, 0);
    idle(1, 0, 0);
    checkOutput("reset_disp_bank", disp_bank, 0);
    checkOutput("reset_swap_pending", swap_pending, 0);
    checkOutput("reset_overflow", overflow, 0);

    idle(1, 1, 0);
    sendByte(8'hF0, 0); sendByte(8'hFF, 0); sendByte(8'h00, 0); sendByte(8'hFF, 0);
    idle(2, 1, 0); idle(2, 0, 0);
    checkOutput("nom_ram_1ff", ram[9'h1FF], 8'h00);
    checkOutput("nom_ram_100", ram[9'h100], 8'hFF);
    checkOutput("nom_disp_bank", disp_bank, 0);
    checkOutput("nom_overflow", overflow, 0);

    idle(1, 1, 0);
    sendByte(8'hF0, 0); sendByte(8'h10, 0); sendByte(8'h33, 0);
    idle(3, 1, 1);
    checkOutput("coll_held", ram[9'h110], 8'h5A);
    idle(1, 1, 0);
    checkOutput("coll_written", ram[9'h110], 8'h33);
    idle(1, 0, 0);

    idle(1, 1, 0);
    sendByte(8'hF0, 0); sendByte(8'h20, 0);
    sendByte(8'hD1, 1); sendByte(8'hD2, 1);
    idle(2, 1, 1);
    checkOutput("ovf_set", overflow, 1);
    idle(1, 1, 0);
    sendByte(8'hE7, 0);
    idle(1, 1, 0); idle(1, 0, 0);
    checkOutput("ovf_ram_120", ram[9'h120], 8'hD1);
    checkOutput("ovf_ram_121", ram[9'h121], 8'hE7);
    checkOutput("ovf_sticky", overflow, 1);
    idle(2, 1, 0);
    checkOutput("ovf_cleared", overflow, 0);
    idle(1, 0, 0);

    idle(1, 1, 0);
    sendByte(8'hA5, 0);
    idle(1, 1, 0); idle(1, 0, 0);
    checkOutput("swap_waiting", swap_pending, 1);
    idle(17, 0, 0);
    checkOutput("swap_still_waiting", disp_bank, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 1);
    idle(1, 0, 0);
    checkOutput("swap_bank", disp_bank, 1);
    checkOutput("swap_cleared", swap_pending, 0);
    idle(1, 1, 0);
    sendByte(8'hF0, 0); sendByte(8'h30, 0); sendByte(8'h99, 0);
    idle(1, 1, 0); idle(1, 0, 0);
    checkOutput("swap_ram_030", ram[9'h030], 8'h99);

    idle(1, 1, 0);
    sendByte(8'h3C, 0); sendByte(8'h11, 0); sendByte(8'h22, 0);
    idle(1, 1, 0); idle(2, 0, 0);

    idle(1, 1, 0);
    sendByte(8'hF0, 0); sendByte(8'h40, 0); sendByte(8'h77, 1);
    idle(1, 1, 1);
    applyStimulus(1, 1, 0, 8'h00, 0, 0);
    idle(1, 0, 0);
    checkOutput("rst_mid_bank", disp_bank, 0);
    checkOutput("rst_mid_ram_040", ram[9'h040], 8'h5A);
    idle(1, 1, 0);
    sendByte(8'hF0, 0); sendByte(8'h41, 0); sendByte(8'h88, 0);
    idle(1, 1, 0); idle(1, 0, 0);
    checkOutput("rst_mid_ram_141", ram[9'h141], 8'h88);
    checkOutput("rst_mid_ram_140", ram[9'h140], 8'h5A);

    for (int fr = 0; fr < 40; fr++) begin
      idle(int'($urandom_range(0, 2)), 0, ($urandom_range(0, 3) == 0));
      applyStimulus(0, 1, 0, 8'h00, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
      n = int'($urandom_range(1, 9));
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 3))
          0, 1:    b = 8'hF0;
          2:       b = 8'hA5;
          default: b = 8'($urandom);
        endcase
        if (k > 0) b = 8'($urandom);
        applyStimulus(($urandom_range(0, 60) == 0), 1, ($urandom_range(0, 9) < 7), b,
                      ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) == 0));
      end
      applyStimulus(0, 0, $urandom_range(0, 1) == 1, 8'($urandom),
                    ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 2));
    end
    idle(3, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_fb_write_ctrl.md
Name: spi_fb_write_ctrl

Overview:
- Sequences the display frame-buffer RAM from the SPI byte stream: decodes command/address/data bytes into RAM writes with address auto-increment.
- Arbitrates the single RAM port between SPI writes and display scan-out reads; scan-out always wins.
- Manages double-buffer bank selection, with swaps applied only on scan frame boundaries.
- Sits between the SPI slave byte receiver and the frame-buffer RAM inside top.

Parameters:
ADDR_W, 8, frame-buffer address width per bank; RAM address is {bank, addr}
CMD_WRITE, 8'hF0, command byte: write data starting at the next (address) byte
CMD_SWAP, 8'hA5, command byte: request display bank swap

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
frame_active  in  1  high while SPI ss is asserted (already synchronised to clk)
rx_valid  in  1  one-cycle strobe: rx_data holds a complete SPI byte
rx_data  in  8  received byte
scan_req  in  1  scan-out read request this cycle
scan_addr  in  ADDR_W  scan-out address within the display bank
frame_sync  in  1  one-cycle pulse at scan frame boundary
scan_rvalid  out  1  mem_rdata is valid for the previous cycle's scan_req
mem_en  out  1  RAM port enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W+1  RAM address {bank, addr}
mem_wdata  out  8  RAM write data
disp_bank  out  1  bank currently shown by scan-out; write bank is ~disp_bank
swap_pending  out  1  swap requested, waiting for frame_sync
overflow  out  1  sticky: a data byte was dropped

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, pending write buffer empty, address counter 0.
- Reset mid-operation: any pending write is discarded; no RAM write occurs in the reset cycle.

FSM (advances only on rx_valid, except frame edges):
- IDLE → CMD on frame_active rising edge; that same edge clears overflow.
- CMD, byte == CMD_WRITE → ADDR.
- CMD, byte == CMD_SWAP → set swap_pending, go to IGNORE.
- CMD, any other byte → IGNORE.
- ADDR: load the address counter with the byte → DATA.
- DATA: each byte is queued as a write to {~disp_bank, addr}, then addr = addr+1 mod 2^ADDR_W (0xFF wraps to 0x00).
- IGNORE: all further bytes are discarded.
- frame_active low in any state → IDLE the next cycle. A write already queued still completes.
- rx_valid and a frame_active falling edge in the same cycle: the byte is processed, then IDLE.

Pending write buffer (1 entry):
- A DATA byte accepted at edge N sets pending with its bank, address and data. The RAM write may issue in cycle N+1.
- A byte is accepted if the buffer is empty or its write issues in the same cycle.
- Otherwise the byte is dropped, overflow is set to 1 and the address counter does not advance.

Port arbitration (combinational each cycle):
- scan_req = 1: mem_en=1, mem_we=0, mem_addr={disp_bank, scan_addr}. scan_rvalid=1 in the next cycle. A pending write waits.
- scan_req = 0 and pending: mem_en=1, mem_we=1, mem_addr/mem_wdata from the buffer. The buffer clears at the edge.
- Neither: mem_en=0, mem_we=0.

Swap:
- On frame_sync with swap_pending=1: disp_bank toggles and swap_pending clears.
- A second SWAP command while a swap is pending has no additional effect.
- CMD_SWAP and frame_sync in the same cycle: the swap waits for the next frame_sync.
- The bank of a queued write is captured at accept time; a later swap does not retarget it.

Decomposition:
- Shared package display_pkg holds CMD_WRITE, CMD_SWAP, ADDR_W default and the FSM state enum (IDLE, CMD, ADDR, DATA, IGNORE).
- One sub-module is natural: fb_port_arbiter, covering the pending buffer, the scan-vs-write mux and scan_rvalid.
- Command FSM, address counter and bank logic stay in the top of this block.

Test Plan:
- Nominal write: frame open, bytes F0, FF, 00, FF, no scan_req. Required: writes 0x00 → addr 0x1FF, then 0xFF → addr 0x100 (write bank 1, address wrap); disp_bank=0; overflow=0.
- Scan collision: hold scan_req=1 for 3 cycles while a data byte is pending. Required: 3 scan reads with scan_rvalid one cycle after each request; the write issues in the first cycle with scan_req=0.
- Overflow: scan_req held high, 2 data bytes arrive. Required: second byte dropped, overflow=1, address advances only once; next frame start clears overflow.
- Swap: send A5, pulse frame_sync 20 cycles later. Required: swap_pending=1 until the pulse, then disp_bank=1 and swap_pending=0; subsequent writes target bank 0.
- Unknown command: frame with 3C, 11, 22. Required: no mem_we; FSM in IGNORE; IDLE one cycle after frame_active falls.
- Reset mid-frame: assert rst while in DATA with a write pending. Required: no write issued; all outputs 0; next frame starts cleanly in CMD.
